// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: state encoding and default parameters shared by rf_window_seq.
package rf_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } rf_seq_state_t;

  localparam int RF_SEQ_WIDTH       = 8;
  localparam int RF_SEQ_CNT_W       = 8;
  localparam int RF_SEQ_TIMEOUT_CYC = 255;

endpackage

// File: rtl/rf_window_seq.sv
// rf_window_seq: drives a RangeFinder (go/finish/data_in) over a window of cfg_len samples.
// Optional idle-input watchdog is enabled by defining RF_SEQ_TIMEOUT_EN.
module rf_window_seq
  import rf_seq_pkg::*;
#(
  parameter int WIDTH       = RF_SEQ_WIDTH,
  parameter int CNT_W       = RF_SEQ_CNT_W,
  parameter int TIMEOUT_CYC = RF_SEQ_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] rf_data,
  output logic             rf_go,
  output logic             rf_finish,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_err,
  output logic             timeout
);

  rf_seq_state_t    r_state;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_last;
  logic             r_aborted;
  logic [WIDTH-1:0] r_result;
  logic             r_result_err;

  logic             w_accept;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout_hit;
  logic             w_start_idle;

  if (TIMEOUT_CYC < 1) begin : g_cfg_chk
    $error("rf_window_seq: TIMEOUT_CYC must be at least 1");
  end

  assign w_start_idle = (r_state == ST_IDLE) && start;
  assign w_accept     = (r_state == ST_RUN) && in_valid;
  assign w_cnt_inc    = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_last       = w_accept && (w_cnt_inc == r_len);

`ifdef RF_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_idle;
  logic            r_timeout;

  assign w_timeout_hit = (r_state == ST_RUN) && !in_valid &&
                         (r_idle == TO_W'(TIMEOUT_CYC - 1));

  // Watchdog: consecutive idle cycles in RUN; timeout flag sticky until next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else if (w_start_idle) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_idle <= '0;
    end else if (w_timeout_hit) begin
      r_idle    <= '0;
      r_timeout <= 1'b1;
    end else if (r_state == ST_RUN) begin
      r_idle <= r_idle + TO_W'(1);
    end else begin
      r_idle <= '0;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign timeout       = 1'b0;
`endif

  // Window sequencer FSM with latched length, sample counter and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_last       <= '0;
      r_aborted    <= 1'b0;
      r_result     <= '0;
      r_result_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt     <= '0;
            r_aborted <= 1'b0;
            if (cfg_len != '0) begin
              r_len   <= cfg_len;
              r_state <= ST_RUN;
            end else begin
              r_result     <= '0;
              r_result_err <= 1'b1;
              r_state      <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_cnt  <= w_cnt_inc;
            r_last <= in_data;
          end
          // A sample accepted alongside abort has already raised rf_go, so it must be flushed
          if (w_last) begin
            r_state <= ST_FLUSH;
          end else if (abort || w_timeout_hit) begin
            if ((r_cnt != '0) || w_accept) begin
              r_aborted <= abort;
              r_state   <= ST_FLUSH;
            end else begin
              r_result     <= '0;
              r_result_err <= 1'b1;
              r_state      <= ST_DONE;
            end
          end
        end
        ST_FLUSH:  r_state <= ST_SETTLE;
        ST_SETTLE: begin
          r_result     <= rf_range;
          r_result_err <= rf_error | r_aborted | timeout;
          r_state      <= ST_DONE;
        end
        ST_DONE:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_RUN);
  assign busy       = (r_state != ST_IDLE);
  assign rf_finish  = (r_state == ST_FLUSH);
  assign done       = (r_state == ST_DONE);
  assign rf_go      = w_accept && (r_cnt == '0);
  assign rf_data    = w_accept ? in_data : r_last;
  assign result     = r_result;
  assign result_err = r_result_err;

endmodule

// File: tb/tb_rf_window_seq.sv
// tb_rf_window_seq: table-driven windows plus hand-written abort/reset/timeout sequences;
// results are checked through a scoreboard queue popped on each done pulse.
module tb_rf_window_seq;

`ifdef RF_SEQ_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 255;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] cfg_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] rf_data;
  logic       rf_go;
  logic       rf_finish;
  logic [7:0] rf_range;
  logic       rf_error;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       result_err;
  logic       timeout;

  rf_window_seq #(.WIDTH(8), .CNT_W(8), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .rf_data(rf_data),
    .rf_go(rf_go), .rf_finish(rf_finish), .rf_range(rf_range), .rf_error(rf_error),
    .busy(busy), .done(done), .result(result), .result_err(result_err), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      len;
    logic [3:0]      gaps;   // bit i: one idle cycle before sample i
    logic [3:0][7:0] data;
    logic [7:0]      range;
    logic            err;
  } vec_t;

  typedef struct packed {
    logic [7:0] res;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         go_cnt  = 0;
  int         fin_cnt = 0;
  logic [7:0] last_smp = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: count go/finish pulses, check their exclusivity, score results on done
  always @(negedge clk) begin
    if (rf_go) go_cnt++;
    if (rf_finish) fin_cnt++;
    if (rf_go || rf_finish) check("go_finish_excl", {31'd0, rf_go & rf_finish}, 32'd0);
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", {24'd0, result}, {24'd0, e.res});
        check("result_err", {31'd0, result_err}, {31'd0, e.err});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input logic [7:0] d, input bit first);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    check("rf_go", {31'd0, rf_go}, {31'd0, first});
    check("rf_data", {24'd0, rf_data}, {24'd0, d});
    check("in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    last_smp = d;
  endtask

  // Closing tail after the last accepted sample (cycle L): finish L+1, done L+3, idle L+4
  task automatic tail(input int go0, input int fin0, input int go_exp);
    in_valid = 1'b0;
    in_data  = 8'hA5;
    @(negedge clk);
    check("finish_L1", {31'd0, rf_finish}, 32'd1);
    check("hold_L1", {24'd0, rf_data}, {24'd0, last_smp});
    check("ready_L1", {31'd0, in_ready}, 32'd0);
    cyc();
    @(negedge clk);
    check("finish_L2", {31'd0, rf_finish}, 32'd0);
    check("done_L2", {31'd0, done}, 32'd0);
    cyc();
    @(negedge clk);
    check("done_L3", {31'd0, done}, 32'd1);
    cyc();
    @(negedge clk);
    check("done_L4", {31'd0, done}, 32'd0);
    check("busy_L4", {31'd0, busy}, 32'd0);
    check("go_count", go_cnt - go0, go_exp);
    check("finish_count", fin_cnt - fin0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int go0, fin0;
    go0 = go_cnt;
    fin0 = fin_cnt;
    rf_range = v.range;
    rf_error = v.err;
    start = 1'b1;
    cfg_len = v.len;
    cyc();
    start = 1'b0;
    sb_q.push_back('{res: v.range, err: v.err});
    check("timeout_clr", {31'd0, timeout}, 32'd0);
    for (int i = 0; i < int'(v.len); i++) begin
      if (v.gaps[i]) begin
        in_valid = 1'b0;
        in_data  = 8'h3C;
        @(negedge clk);
        check("gap_hold", {24'd0, rf_data}, {24'd0, last_smp});
        check("gap_go", {31'd0, rf_go}, 32'd0);
        check("gap_ready", {31'd0, in_ready}, 32'd1);
        cyc();
      end
      drive_sample(v.data[i], i == 0);
    end
    tail(go0, fin0, 1);
  endtask

  vec_t vecs[4];
  int   go0, fin0;

  initial begin
    vecs[0] = '{8'd4, 4'b0000, {8'd9, 8'd7, 8'd3, 8'd10}, 8'd6, 1'b0};
    vecs[1] = '{8'd3, 4'b0110, {8'd0, 8'd1, 8'd20, 8'd5}, 8'd19, 1'b0};
    vecs[2] = '{8'd1, 4'b0000, {8'd0, 8'd0, 8'd0, 8'hFF}, 8'd0, 1'b1};
    vecs[3] = '{8'd2, 4'b0001, {8'd0, 8'd0, 8'h7F, 8'h80}, 8'd1, 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_len = 8'd0;
    in_valid = 1'b0; in_data = 8'd0; rf_range = 8'd0; rf_error = 1'b0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_rf_data", {24'd0, rf_data}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_result_err", {31'd0, result_err}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Table: windows run back to back, each start lands in the cycle busy falls
    for (int k = 0; k < 4; k++) run_vec(vecs[k]);
    cyc();

    // Zero-length window: done next cycle with error, no go/finish
    go0 = go_cnt; fin0 = fin_cnt;
    in_valid = 1'b1; in_data = 8'h44;
    start = 1'b1; cfg_len = 8'd0;
    cyc();
    start = 1'b0;
    sb_q.push_back('{res: 8'd0, err: 1'b1});
    @(negedge clk);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("len0_busy", {31'd0, busy}, 32'd0);
    check("len0_go", go_cnt - go0, 32'd0);
    check("len0_finish", fin_cnt - fin0, 32'd0);
    cyc();

    // Abort after 2 of 5 samples: clean flush, error flagged
    go0 = go_cnt; fin0 = fin_cnt;
    rf_range = 8'd42; rf_error = 1'b0;
    start = 1'b1; cfg_len = 8'd5;
    cyc();
    start = 1'b0;
    drive_sample(8'd11, 1'b1);
    drive_sample(8'd22, 1'b0);
    in_valid = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    sb_q.push_back('{res: 8'd42, err: 1'b1});
    @(negedge clk);
    check("abort2_finish", {31'd0, rf_finish}, 32'd1);
    cyc();
    cyc();
    @(negedge clk);
    check("abort2_done", {31'd0, done}, 32'd1);
    cyc();
    @(negedge clk);
    check("abort2_idle", {31'd0, busy}, 32'd0);
    check("abort2_fin_cnt", fin_cnt - fin0, 32'd1);
    cyc();

    // Abort before any sample: immediate done, no go/finish
    go0 = go_cnt; fin0 = fin_cnt;
    start = 1'b1; cfg_len = 8'd5;
    cyc();
    start = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    sb_q.push_back('{res: 8'd0, err: 1'b1});
    @(negedge clk);
    check("abort0_done", {31'd0, done}, 32'd1);
    check("abort0_finish", {31'd0, rf_finish}, 32'd0);
    cyc();
    @(negedge clk);
    check("abort0_idle", {31'd0, busy}, 32'd0);
    check("abort0_go", go_cnt - go0, 32'd0);
    check("abort0_fin", fin_cnt - fin0, 32'd0);
    cyc();

    // Abort coincident with last sample completes normally; start while busy is ignored
    go0 = go_cnt; fin0 = fin_cnt;
    rf_range = 8'd9; rf_error = 1'b0;
    start = 1'b1; cfg_len = 8'd2;
    cyc();
    cfg_len = 8'd1;
    sb_q.push_back('{res: 8'd9, err: 1'b0});
    drive_sample(8'd50, 1'b1);
    start = 1'b0;
    abort = 1'b1;
    drive_sample(8'd60, 1'b0);
    abort = 1'b0;
    tail(go0, fin0, 1);
    cyc();

    // Reset mid-window: outputs clear asynchronously, no finish issued
    fin0 = fin_cnt;
    start = 1'b1; cfg_len = 8'd5;
    cyc();
    start = 1'b0;
    drive_sample(8'd70, 1'b1);
    drive_sample(8'd80, 1'b0);
    in_valid = 1'b1; in_data = 8'h55;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd0);
    check("mrst_rf_data", {24'd0, rf_data}, 32'd0);
    check("mrst_go", {31'd0, rf_go}, 32'd0);
    check("mrst_result", {24'd0, result}, 32'd0);
    check("mrst_timeout", {31'd0, timeout}, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    in_valid = 1'b0;
    last_smp = 8'd0;
    check("mrst_no_finish", fin_cnt - fin0, 32'd0);
    run_vec(vecs[0]);
    cyc();

`ifdef RF_SEQ_TIMEOUT_EN
    // Watchdog: one sample then TO_CYC idle cycles forces flush with error
    rf_range = 8'd5; rf_error = 1'b0;
    start = 1'b1; cfg_len = 8'd3;
    cyc();
    start = 1'b0;
    drive_sample(8'd33, 1'b1);
    in_valid = 1'b0;
    for (int k = 1; k <= TO_CYC; k++) begin
      @(negedge clk);
      check("to_wait_flag", {31'd0, timeout}, 32'd0);
      check("to_wait_finish", {31'd0, rf_finish}, 32'd0);
      cyc();
    end
    sb_q.push_back('{res: 8'd5, err: 1'b1});
    @(negedge clk);
    check("to_flag", {31'd0, timeout}, 32'd1);
    check("to_finish", {31'd0, rf_finish}, 32'd1);
    cyc();
    cyc();
    @(negedge clk);
    check("to_done", {31'd0, done}, 32'd1);
    cyc();
    @(negedge clk);
    check("to_sticky", {31'd0, timeout}, 32'd1);
    check("to_idle", {31'd0, busy}, 32'd0);
    cyc();
    run_vec(vecs[2]);
    cyc();
`else
    // No watchdog: RUN waits indefinitely until aborted
    rf_range = 8'd5; rf_error = 1'b0;
    start = 1'b1; cfg_len = 8'd3;
    cyc();
    start = 1'b0;
    drive_sample(8'd33, 1'b1);
    in_valid = 1'b0;
    repeat (20) cyc();
    @(negedge clk);
    check("nowd_busy", {31'd0, busy}, 32'd1);
    check("nowd_timeout", {31'd0, timeout}, 32'd0);
    check("nowd_finish", {31'd0, rf_finish}, 32'd0);
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    sb_q.push_back('{res: 8'd5, err: 1'b1});
    repeat (4) cyc();
`endif

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
